// File: rtl/lm_multi_channel.sv
// lm_multi_channel
//   Latches NUM_CH independent data channels into hold registers, keeps each
//   value visible for a programmable time, flags overruns, and drives one
//   channel (or a merged view) onto the board LEDs.
//
// Ports
//   i_clk        system clock
//   i_rst        synchronous active-high reset
//   i_mode       00 manual, 01 rotate, 10/11 merge
//   i_ch_sel     channel shown in manual mode
//   i_clear      single-cycle pulse clearing all hold state and overrun flags
//   i_ch_data    channel i at [i*WIDTH_CH +: WIDTH_CH]
//   i_ch_valid   per-channel load strobe
//   o_leds       {alive, disp_active, disp_data}
//   o_disp_ch    index of channel currently shown (0 in merge mode)
//   o_ch_active  per-channel active flag
//   o_overrun    sticky flag: valid arrived while channel already active
module lm_multi_channel #(
    parameter int unsigned       NUM_CH        = 3,
    parameter int unsigned       CH_W          = 2,
    parameter int unsigned       WIDTH_CH      = 8,
    parameter int unsigned       HOLD_CYCLES   = 50_000_000,
    parameter int unsigned       ROTATE_CYCLES = 100_000_000,
    parameter int unsigned       CNT_W         = 27,
    parameter logic [NUM_CH-1:0] STICKY_MASK   = '0
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [1:0]                 i_mode,
    input  logic [CH_W-1:0]            i_ch_sel,
    input  logic                       i_clear,
    input  logic [NUM_CH*WIDTH_CH-1:0] i_ch_data,
    input  logic [NUM_CH-1:0]          i_ch_valid,
    output logic [WIDTH_CH+1:0]        o_leds,
    output logic [CH_W-1:0]            o_disp_ch,
    output logic [NUM_CH-1:0]          o_ch_active,
    output logic [NUM_CH-1:0]          o_overrun
);

    typedef enum logic [1:0] {
        MODE_MANUAL    = 2'b00,
        MODE_ROTATE    = 2'b01,
        MODE_MERGE     = 2'b10,
        MODE_MERGE_ALT = 2'b11
    } mode_e;

    mode_e                              w_mode;

    logic [NUM_CH-1:0][WIDTH_CH-1:0]    r_hold;
    logic [NUM_CH-1:0][CNT_W-1:0]       r_timer;
    logic [NUM_CH-1:0]                  r_active;
    logic [NUM_CH-1:0]                  r_overrun;

    logic [CNT_W-1:0]                   r_rot_cnt;
    logic [CH_W-1:0]                    r_ptr;
    logic [CH_W-1:0]                    w_ptr_next;
    int unsigned                        w_ptr_int;
    int unsigned                        w_best;
    int unsigned                        w_dist;

    logic [CH_W-1:0]                    w_sel;
    logic [WIDTH_CH-1:0]                w_disp_data;
    logic                               w_disp_active;
    logic [CH_W-1:0]                    w_disp_ch;

    logic                               r_alive;
    logic                               r_disp_active;
    logic [WIDTH_CH-1:0]                r_disp_data;
    logic [CH_W-1:0]                    r_disp_ch;

    assign w_mode = mode_e'(i_mode);

    // Per-channel hold state. Valid outranks clear; a clear in the same cycle
    // as a retrigger only suppresses the overrun flag.
    always_ff @(posedge i_clk) begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (i_rst) begin
                r_hold[i]    <= '0;
                r_active[i]  <= 1'b0;
                r_timer[i]   <= '0;
                r_overrun[i] <= 1'b0;
            end else if (i_ch_valid[i]) begin
                r_hold[i]    <= i_ch_data[i*WIDTH_CH +: WIDTH_CH];
                r_active[i]  <= 1'b1;
                r_timer[i]   <= CNT_W'(HOLD_CYCLES - 1);
                r_overrun[i] <= i_clear ? 1'b0 : (r_overrun[i] | r_active[i]);
            end else if (i_clear) begin
                r_hold[i]    <= '0;
                r_active[i]  <= 1'b0;
                r_timer[i]   <= '0;
                r_overrun[i] <= 1'b0;
            end else if (r_active[i] && !STICKY_MASK[i]) begin
                if (r_timer[i] == '0) begin
                    r_active[i] <= 1'b0;
                    r_hold[i]   <= '0;
                end else begin
                    r_timer[i] <= r_timer[i] - CNT_W'(1);
                end
            end
        end
    end

    // Next rotate target: the active channel at the smallest nonzero forward
    // distance from the current pointer, modulo NUM_CH.
    always_comb begin
        w_ptr_next = r_ptr;
        w_ptr_int  = 32'(r_ptr);
        w_best     = NUM_CH;
        w_dist     = 0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (r_active[k] && (k != w_ptr_int)) begin
                w_dist = (k > w_ptr_int) ? (k - w_ptr_int) : (k + NUM_CH - w_ptr_int);
                if (w_dist < w_best) begin
                    w_best     = w_dist;
                    w_ptr_next = CH_W'(k);
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rot_cnt <= '0;
            r_ptr     <= '0;
        end else if (w_mode != MODE_ROTATE) begin
            r_rot_cnt <= '0;
        end else if (r_rot_cnt == CNT_W'(ROTATE_CYCLES - 1)) begin
            r_rot_cnt <= '0;
            r_ptr     <= w_ptr_next;
        end else begin
            r_rot_cnt <= r_rot_cnt + CNT_W'(1);
        end
    end

    // Display selection; an out-of-range manual select matches no channel
    // and therefore shows zero data and inactive.
    always_comb begin
        w_sel         = i_ch_sel;
        w_disp_data   = '0;
        w_disp_active = 1'b0;
        w_disp_ch     = '0;
        case (w_mode)
            MODE_MANUAL: begin
                w_sel     = i_ch_sel;
                w_disp_ch = i_ch_sel;
            end
            MODE_ROTATE: begin
                w_sel     = r_ptr;
                w_disp_ch = r_ptr;
            end
            default: begin
                w_disp_ch = '0;
            end
        endcase
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (w_mode == MODE_MERGE || w_mode == MODE_MERGE_ALT) begin
                w_disp_data   = w_disp_data | r_hold[k];
                w_disp_active = w_disp_active | r_active[k];
            end else if (CH_W'(k) == w_sel) begin
                w_disp_data   = r_hold[k];
                w_disp_active = r_active[k];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_alive       <= 1'b0;
            r_disp_active <= 1'b0;
            r_disp_data   <= '0;
            r_disp_ch     <= '0;
        end else begin
            r_alive       <= 1'b1;
            r_disp_active <= w_disp_active;
            r_disp_data   <= w_disp_data;
            r_disp_ch     <= w_disp_ch;
        end
    end

    assign o_leds      = {r_alive, r_disp_active, r_disp_data};
    assign o_disp_ch   = r_disp_ch;
    assign o_ch_active = r_active;
    assign o_overrun   = r_overrun;

endmodule

// File: tb/tb_lm_multi_channel.sv
// Directed bench for lm_multi_channel with NUM_CH=3, WIDTH_CH=4,
// HOLD_CYCLES=4, ROTATE_CYCLES=8, STICKY_MASK=3'b100.
module tb_lm_multi_channel;

    logic        clk;
    logic        rst;
    logic [1:0]  mode;
    logic [1:0]  ch_sel;
    logic        clear;
    logic [11:0] ch_data;
    logic [2:0]  ch_valid;
    logic [5:0]  leds;
    logic [1:0]  disp_ch;
    logic [2:0]  ch_active;
    logic [2:0]  overrun;

    int n_chk;
    int n_err;

    lm_multi_channel #(
        .NUM_CH        (3),
        .CH_W          (2),
        .WIDTH_CH      (4),
        .HOLD_CYCLES   (4),
        .ROTATE_CYCLES (8),
        .CNT_W         (4),
        .STICKY_MASK   (3'b100)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_mode      (mode),
        .i_ch_sel    (ch_sel),
        .i_clear     (clear),
        .i_ch_data   (ch_data),
        .i_ch_valid  (ch_valid),
        .o_leds      (leds),
        .o_disp_ch   (disp_ch),
        .o_ch_active (ch_active),
        .o_overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [1:0] exp_ch;
        n_chk    = 0;
        n_err    = 0;
        rst      = 1'b1;
        mode     = 2'b00;
        ch_sel   = 2'd0;
        clear    = 1'b0;
        ch_data  = '0;
        ch_valid = '0;

        // Reset for three edges
        tick();
        chk("rst_leds_e1", 32'(leds), 32'h0);
        tick();
        tick();
        chk("rst_leds", 32'(leds), 32'h0);
        chk("rst_disp_ch", 32'(disp_ch), 32'h0);
        chk("rst_active", 32'(ch_active), 32'h0);
        chk("rst_overrun", 32'(overrun), 32'h0);
        rst = 1'b0;
        tick();
        tick();
        chk("idle_leds", 32'(leds), 32'(6'b100000));

        // Hold expiry on channel 0
        ch_valid = 3'b001;
        ch_data  = 12'h00A;
        tick();                                   // edge k
        ch_valid = '0;
        chk("exp_active_k", 32'(ch_active), 32'h1);
        tick();                                   // k+1
        chk("exp_leds_k1", 32'(leds), 32'(6'b111010));
        tick();
        tick();                                   // k+3
        chk("exp_active_k3", 32'(ch_active), 32'h1);
        tick();                                   // k+4
        chk("exp_active_k4", 32'(ch_active), 32'h0);
        chk("exp_leds_k4", 32'(leds), 32'(6'b111010));
        tick();                                   // k+5
        chk("exp_leds_k5", 32'(leds), 32'(6'b100000));

        // Retrigger and overrun on channel 1
        ch_sel   = 2'd1;
        ch_valid = 3'b010;
        ch_data  = 12'h030;
        tick();                                   // e0
        ch_valid = '0;
        chk("ovr_none_yet", 32'(overrun), 32'h0);
        tick();                                   // e1
        chk("ovr_leds_first", 32'(leds), 32'(6'b110011));
        ch_valid = 3'b010;
        ch_data  = 12'h050;
        tick();                                   // e2
        ch_valid = '0;
        chk("ovr_flag", 32'(overrun), 32'(3'b010));
        tick();                                   // e3
        chk("ovr_leds_last", 32'(leds), 32'(6'b110101));
        tick();
        tick();                                   // e5
        chk("ovr_active_e5", 32'(ch_active), 32'(3'b010));
        tick();                                   // e6
        chk("ovr_active_e6", 32'(ch_active), 32'h0);
        chk("ovr_kept", 32'(overrun), 32'(3'b010));
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("ovr_cleared", 32'(overrun), 32'h0);
        tick();
        chk("ovr_leds_clr", 32'(leds), 32'(6'b100000));

        // Sticky channel 2
        ch_sel   = 2'd2;
        ch_valid = 3'b100;
        ch_data  = 12'hF00;
        tick();
        ch_valid = '0;
        repeat (20) tick();
        chk("sticky_active", 32'(ch_active), 32'(3'b100));
        chk("sticky_leds", 32'(leds), 32'(6'b111111));
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("sticky_cleared", 32'(ch_active), 32'h0);

        // Rotate: ch2 sticky, ch0 retriggered every 3 cycles up to c=24
        ch_data = 12'hF01;
        mode    = 2'b01;
        for (int c = 0; c <= 40; c++) begin
            if (c == 0)
                ch_valid = 3'b101;
            else if ((c % 3 == 0) && (c <= 24))
                ch_valid = 3'b001;
            else
                ch_valid = 3'b000;
            tick();
            if (c < 8)       exp_ch = 2'd0;
            else if (c < 16) exp_ch = 2'd2;
            else if (c < 24) exp_ch = 2'd0;
            else             exp_ch = 2'd2;
            chk($sformatf("rot_disp_ch_c%0d", c), 32'(disp_ch), 32'(exp_ch));
        end
        ch_valid = '0;
        chk("rot_leds_ch2", 32'(leds), 32'(6'b111111));
        chk("rot_ch0_expired", 32'(ch_active), 32'(3'b100));

        // Merge and out-of-range select
        mode  = 2'b00;
        clear = 1'b1;
        tick();
        clear    = 1'b0;
        mode     = 2'b10;
        ch_valid = 3'b011;
        ch_data  = 12'h041;
        tick();
        ch_valid = '0;
        tick();
        chk("merge_leds", 32'(leds), 32'(6'b110101));
        chk("merge_disp_ch", 32'(disp_ch), 32'h0);
        mode   = 2'b00;
        ch_sel = 2'd3;
        tick();
        chk("oor_leds", 32'(leds), 32'(6'b100000));
        chk("oor_disp_ch", 32'(disp_ch), 32'h3);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/lm_multi_channel.md
# lm_multi_channel

Parametrised LED manager that latches NUM_CH independent data/error channels into hold registers. Each held value stays visible for a programmable time, overruns are flagged, and one channel is driven onto the board LEDs according to a run-time display mode. The block sits between the UART/CM error and data sources and the board LED pins. It supersedes the fixed three-source LED mux with per-channel hold timers, sticky channels, auto-rotation and a merged view.

## Interface
- NUM_CH, 3: number of input channels (2..8)
- CH_W, 2: width of channel index, must satisfy 2**CH_W >= NUM_CH
- WIDTH_CH, 8: data width per channel
- HOLD_CYCLES, 50_000_000: cycles a non-sticky channel stays active after its last valid (>= 2)
- ROTATE_CYCLES, 100_000_000: dwell cycles per channel in rotate mode (>= 2)
- CNT_W, 27: width of hold and rotate counters, must hold max(HOLD_CYCLES, ROTATE_CYCLES)-1
- STICKY_MASK, {NUM_CH{1'b0}}: bit i = 1 means channel i never expires and is only cleared by clear
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- mode  in  2  00 manual, 01 rotate, 10/11 merge
- ch_sel  in  CH_W  channel displayed in manual mode
- clear  in  1  single-cycle pulse clearing all hold state and overrun flags
- ch_data  in  NUM_CH*WIDTH_CH  channel i occupies bits [i*WIDTH_CH +: WIDTH_CH]
- ch_valid  in  NUM_CH  per-channel single-cycle load strobe
- leds  out  WIDTH_CH+2  {alive, disp_active, disp_data}
- disp_ch  out  CH_W  index of channel currently shown (0 in merge mode)
- ch_active  out  NUM_CH  per-channel active flag
- overrun  out  NUM_CH  sticky: valid arrived while channel already active

## Operation
- Per channel i, at each edge, in priority order:
  - rst: hold_i = 0, active_i = 0, timer_i = 0, overrun_i = 0.
  - ch_valid[i]: hold_i = data slice, active_i = 1, timer_i = HOLD_CYCLES-1. If active_i was already 1, overrun_i = 1, unless clear is high in the same cycle, in which case overrun_i = 0.
  - clear: hold_i = 0, active_i = 0, timer_i = 0, overrun_i = 0.
  - Active and not sticky with timer_i == 0: active_i = 0, hold_i = 0.
  - Active and not sticky: timer_i decrements.
  - Sticky channels ignore the timer.
- Retrigger: a valid on an active channel reloads the timer and overwrites the data (last value wins).
- Manual mode: displayed index = ch_sel. If ch_sel >= NUM_CH, disp_data = 0, disp_active = 0, and disp_ch = ch_sel.
- Rotate mode:
  - rot_cnt counts 0..ROTATE_CYCLES-1 and is held at 0 whenever mode != 01.
  - On the wrap edge, ptr advances to the smallest index after ptr (modulo NUM_CH, wrapping) whose active flag is 1.
  - If no other channel is active, ptr is unchanged.
  - ptr keeps its value across mode changes.
  - disp_ch = ptr.
- Merge mode: disp_data = bitwise OR of all hold_i, disp_active = OR of all active_i, disp_ch = 0.
- alive = 1 in every cycle after reset releases, 0 during reset.
- All outputs are registered.

## Timing
- Reset values: leds = 0, disp_ch = 0, ch_active = 0, overrun = 0, ptr = 0, rot_cnt = 0.
- ch_active/overrun update at the edge that samples ch_valid, so they are visible one cycle later.
- leds/disp_ch are registered from hold state and mode. Data sampled with ch_valid at edge k appears on leds after edge k+1, a latency of 2 cycles.
- A non-sticky channel loaded at edge k (no retrigger) has active = 1 after edges k..k+HOLD_CYCLES-1 and drops after edge k+HOLD_CYCLES. leds clears one cycle later.
- mode/ch_sel changes take effect on leds after one edge.
- In rotate mode, the pointer moves every ROTATE_CYCLES cycles. The first move comes ROTATE_CYCLES edges after entering the mode.
- Simultaneous valids on several channels are all accepted in the same cycle. There is no backpressure.

## Test plan
Parameters for all scenarios: NUM_CH=3, WIDTH_CH=4, HOLD_CYCLES=4, ROTATE_CYCLES=8, STICKY_MASK=3'b100.

- Reset then idle:
  - Stimulus: hold rst high 3 cycles, then release.
  - Required: all outputs 0 during reset; leds = 6'b100000 from the second edge after release.
- Hold expiry:
  - Stimulus: manual mode, ch_sel=0, ch_valid[0] with data 4'hA at edge k.
  - Required: leds = 6'b11_1010 after edge k+1; ch_active[0] falls after edge k+4; leds = 6'b10_0000 after edge k+5.
- Retrigger and overrun:
  - Stimulus: valid on channel 1 with 4'h3, then 4'h5 two cycles later.
  - Required: overrun[1] = 1; displayed data 4'h5; expiry 4 cycles after the second valid.
  - Stimulus: clear pulse.
  - Required: overrun[1] = 0 and leds data 0.
- Sticky channel:
  - Stimulus: valid on channel 2 with 4'hF, wait 20 cycles.
  - Required: ch_active[2] still 1.
  - Stimulus: clear.
  - Required: ch_active[2] = 0.
- Rotate:
  - Stimulus: channels 0 and 2 active (channel 2 sticky, channel 0 retriggered every 3 cycles), mode=01.
  - Required: disp_ch alternates 0→2→0 every 8 cycles; channel 1 is never shown.
  - Stimulus: channel 0 expires.
  - Required: disp_ch stays 2.
- Merge and out-of-range select:
  - Stimulus: channel 0 = 4'h1 and channel 1 = 4'h4 active, mode=10.
  - Required: disp_data = 4'h5, disp_ch = 0.
  - Stimulus: mode=00, ch_sel=3.
  - Required: disp_data = 0, disp_active = 0.
